// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: three-requester AXI read arbiter with one outstanding transaction.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority dcache > uncache > icache.
module axi_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          s_arvalid,
    input  logic [3*ADDR_W-1:0] s_araddr,
    input  logic [3*8-1:0]      s_arlen,
    input  logic [3*3-1:0]      s_arsize,
    input  logic [3*2-1:0]      s_arburst,
    input  logic [3*4-1:0]      s_arid,
    output logic [2:0]          s_arready,
    input  logic [2:0]          s_rready,
    output logic [2:0]          s_rvalid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                m_arvalid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic [3:0]          m_arid,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    output logic                m_rready,
    output logic                len_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d, win;
    logic [7:0]  beat_q, beat_d, len_q, len_d;
    logic        len_err_q, len_err_d;
    logic        ar_hs, r_hs;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // ptr_q holds the last grant; search starts one past it
    logic [1:0] ptr_q, ptr_d, p0, p1, p2;
    function automatic logic [1:0] nxt(input logic [1:0] x);
        return x == 2'd2 ? 2'd0 : x + 2'd1;
    endfunction
    always_comb begin
        p0 = nxt(ptr_q);
        p1 = nxt(p0);
        p2 = nxt(p1);
        win = s_arvalid[p0] ? p0 : s_arvalid[p1] ? p1 : p2;
        ptr_d = (state_q == DATA && r_hs && m_rlast) ? grant_q : ptr_q;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr_q <= 2'd0;
        else       ptr_q <= ptr_d;
`else
    always_comb win = s_arvalid[1] ? 2'd1 : s_arvalid[2] ? 2'd2 : 2'd0;
`endif

    always_comb begin
        m_araddr  = s_araddr[ADDR_W*grant_q +: ADDR_W];
        m_arlen   = s_arlen[8*grant_q +: 8];
        m_arsize  = s_arsize[3*grant_q +: 3];
        m_arburst = s_arburst[2*grant_q +: 2];
        m_arid    = s_arid[4*grant_q +: 4];
        m_arvalid = (state_q == ADDR) && s_arvalid[grant_q];
        s_arready = (state_q == ADDR && m_arready) ? 3'b001 << grant_q : 3'b000;
        s_rvalid  = (state_q == DATA && m_rvalid) ? 3'b001 << grant_q : 3'b000;
        m_rready  = (state_q == DATA) && s_rready[grant_q];
        s_rdata   = m_rdata;
        s_rresp   = m_rresp;
        s_rlast   = m_rlast;
        len_err   = len_err_q;
        ar_hs     = m_arvalid && m_arready;
        r_hs      = m_rvalid && m_rready;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        len_d     = len_q;
        len_err_d = len_err_q;
        case (state_q)
            IDLE: if (|s_arvalid) begin
                grant_d = win;
                state_d = ADDR;
            end
            ADDR: if (ar_hs) begin
                len_d   = m_arlen;
                beat_d  = 8'd0;
                state_d = DATA;
            end
            DATA: if (r_hs) begin
                beat_d = beat_q + 8'd1;
                if (m_rlast) state_d = IDLE;
                // early rlast, or a beat past arlen without rlast
                if (m_rlast ? beat_q != len_q : beat_q == len_q) len_err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 2'd0;
            beat_q    <= 8'd0;
            len_q     <= 8'd0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
            len_err_q <= len_err_d;
        end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed and randomized checks of axi_read_arbiter against a transaction-level model.
module tb_axi_read_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    logic          clk = 0, reset;
    logic [2:0]    req, s_arready, s_rready, s_rvalid;
    logic [AW-1:0] addr [3];
    logic [7:0]    len [3];
    logic [3:0]    id [3];
    logic [DW-1:0] s_rdata, m_rdata, ar_a;
    logic [1:0]    s_rresp, m_rresp, m_arburst;
    logic          s_rlast, m_arvalid, m_arready, m_rvalid, m_rlast, m_rready, len_err;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [3:0]    m_arid;
    logic [AW-1:0] m_araddr;
    int vectors = 0, miscompares = 0;
    int last_g = 0;
    bit err_m = 0;

    always #5 clk = ~clk;

    axi_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .s_arvalid(req), .s_araddr({addr[2], addr[1], addr[0]}), .s_arlen({len[2], len[1], len[0]}),
        .s_arsize({3'd2, 3'd1, 3'd0}), .s_arburst({2'd0, 2'd2, 2'd1}), .s_arid({id[2], id[1], id[0]}),
        .s_arready(s_arready), .s_rready(s_rready), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arid(m_arid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rready(m_rready), .len_err(len_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Winner among the requesting bits, following the arbitration rule of this build
    function automatic int arb(input logic [2:0] r);
`ifdef AXI_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) if (r[(last_g + 1 + k) % 3]) return (last_g + 1 + k) % 3;
`else
        int ord [3] = '{1, 2, 0};
        for (int k = 0; k < 3; k++) if (r[ord[k]]) return ord[k];
`endif
        return 0;
    endfunction

    task automatic quiet_checks(input string tag);
        chk({tag, "_arvalid"}, m_arvalid, 0);
        chk({tag, "_arready"}, s_arready, 0);
        chk({tag, "_rvalid"}, s_rvalid, 0);
        chk({tag, "_rready"}, m_rready, 0);
        chk({tag, "_len_err"}, len_err, 0);
    endtask

    // One full transaction; want>=0 forces the expected winner, abort>=0 pulses reset after that many beats
    task automatic run_txn(input int want, input int stall, input int last_beat, input int abort, input bit poke);
        int w, acc, cyc;
        logic [2:0] rr, oh;
        bit hs, done;
        w = want >= 0 ? want : arb(req);
        oh = 3'b001 << w;
        chk("idle_arvalid", m_arvalid, 0);
        chk("idle_rready", m_rready, 0);
        tick;
        for (int s = 0; s < stall; s++) begin
            m_arready = 0;
            if (poke && w != 1) req[1] = 1;
            #1;
            chk("ar_valid_stall", m_arvalid, 1);
            chk("ar_addr_stall", m_araddr, addr[w]);
            chk("ar_ready_stall", s_arready, 0);
            tick;
        end
        m_arready = 1;
        #1;
        chk("ar_valid", m_arvalid, 1);
        chk("ar_addr", m_araddr, addr[w]);
        chk("ar_len", m_arlen, len[w]);
        chk("ar_id", m_arid, id[w]);
        chk("ar_size", m_arsize, w);
        chk("ar_burst", m_arburst, w == 0 ? 1 : w == 1 ? 2 : 0);
        chk("ar_ready", s_arready, oh);
        tick;
        m_arready = 0;
        req[w] = 0;
        acc = 0;
        cyc = 0;
        done = 0;
        while (!done) begin
            m_rvalid = ($urandom_range(0, 3) != 0);
            m_rdata = $urandom;
            m_rresp = 2'($urandom);
            m_rlast = (acc == last_beat);
            rr = 3'($urandom);
            rr[w] = ($urandom_range(0, 3) != 0);
            s_rready = rr;
            #1;
            chk("r_valid", s_rvalid, m_rvalid ? oh : 3'b000);
            chk("r_ready", m_rready, rr[w]);
            chk("r_data", {s_rresp, s_rlast, s_rdata}, {m_rresp, m_rlast, m_rdata});
            chk("ar_quiet", m_arvalid, 0);
            hs = m_rvalid && rr[w];
            if (hs) begin
                if (m_rlast ? acc != len[w] : acc == len[w]) err_m = 1;
                acc++;
            end
            done = hs && m_rlast;
            tick;
            if (hs && acc == abort) begin
                reset = 1;
                m_rvalid = 1;
                s_rready = 3'b111;
                err_m = 0;
                last_g = 0;
                #1;
                quiet_checks("rst_mid");
                tick;
                quiet_checks("rst_hold");
                reset = 0;
                m_rvalid = 0;
                s_rready = 0;
                return;
            end
            if (++cyc > 400) begin
                chk("r_timeout", 1, 0);
                done = 1;
            end
        end
        m_rvalid = 0;
        s_rready = 0;
        m_rlast = 0;
        last_g = w;
        #1;
        chk("post_rready", m_rready, 0);
        chk("post_rvalid", s_rvalid, 0);
        chk("len_err", len_err, err_m);
    endtask

    initial begin
        reset = 1;
        req = 0;
        s_rready = 0;
        m_arready = 0;
        m_rvalid = 0;
        m_rdata = 0;
        m_rresp = 0;
        m_rlast = 0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 32'h1000_0000 * (i + 1);
            len[i] = 8'd3;
            id[i] = 4'(i + 5);
        end
        tick;
        m_rvalid = 1;
        s_rready = 3'b111;
        req = 3'b111;
        #1;
        quiet_checks("reset");
        tick;
        reset = 0;
        req = 0;
        m_rvalid = 0;
        s_rready = 0;
        tick;

        // single icache burst
        addr[0] = 32'h1FC0_0000;
        req = 3'b001;
        run_txn(0, 0, 3, -1, 0);
        // simultaneous requests
        req = 3'b111;
        run_txn(1, 0, 3, -1, 0);
        run_txn(2, 0, 3, -1, 0);
        run_txn(0, 1, 3, -1, 0);
        // uncache stalled on AR while dcache arrives
        len[2] = 0;
        req = 3'b100;
        run_txn(2, 5, 0, -1, 1);
        run_txn(1, 0, 3, -1, 0);
        // early rlast then a clean burst
        req = 3'b010;
        run_txn(1, 0, 2, -1, 0);
        chk("err_set", len_err, 1);
        req = 3'b001;
        run_txn(0, 0, 3, -1, 0);
        chk("err_sticky", len_err, 1);
        // reset in the middle of a dcache burst
        req = 3'b010;
        run_txn(1, 0, 3, 1, 0);
        req = 3'b010;
        run_txn(1, 0, 3, -1, 0);
`ifdef AXI_ARB_ROUND_ROBIN_EN
        req = 3'b111;
        run_txn(-1, 0, 3, -1, 0);
        reset = 1;
        tick;
        reset = 0;
        last_g = 0;
        err_m = 0;
        req = 3'b111;
        run_txn(1, 0, 3, -1, 0);
        run_txn(2, 0, 3, -1, 0);
        run_txn(0, 0, 3, -1, 0);
        for (int k = 0; k < 4; k++) begin
            req = 3'b011;
            run_txn(k % 2 == 0 ? 1 : 0, 0, 3, -1, 0);
        end
`endif
        for (int t = 0; t < 40; t++) begin
            int w, lb;
            req = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                addr[i] = $urandom;
                len[i] = 8'($urandom_range(0, 5));
                id[i] = 4'($urandom);
            end
            w = arb(req);
            lb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len[w] + 2) : len[w];
            run_txn(-1, $urandom_range(0, 2), lb, -1, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
